r0_seq: RTL

- Sequencer and arbiter for the R0 flag register (Z M V C L E G Y X).
- Four requesters share the R0 update strobes: bus write of R0 from W, ALU flag update, compare (LEG) latch, and shifter X/Y update.
- Grants one requester at a time and runs a fixed SETUP/STROBE/HOLD sequence.
- Generates strob1, the ust_* enables, the w_* load commands and the cleg_ clock pulse consumed by R0.

---
 rtl/r0_seq.sv | 207 ++++++++++++++++++++
 1 files changed

// File: rtl/r0_seq.sv
// R0 flag-register update sequencer: arbitrates four requesters and drives the
// SETUP/STROBE/HOLD strobe, flag-enable, load and LEG-clock outputs to R0.
module r0_seq #(
    parameter int STROBE_LEN = 1
) (
    input  logic       clk_sys,
    input  logic       zer_,
    input  logic       wr_req,
    input  logic [2:0] wr_sel,
    output logic       wr_ack,
    input  logic       alu_req,
    input  logic [2:0] alu_sel,
    output logic       alu_ack,
    input  logic       cmp_req,
    output logic       cmp_ack,
    input  logic       sh_req,
    input  logic [1:0] sh_sel,
    output logic       sh_ack,
    output logic       strob1,
    output logic       ust_z,
    output logic       ust_v,
    output logic       ust_mc,
    output logic       ust_y,
    output logic       ust_x,
    output logic       w_zmvc,
    output logic       w_legy,
    output logic       w8_x,
    output logic       cleg_,
    output logic       busy
);

    typedef enum logic [1:0] {ST_IDLE, ST_SETUP, ST_STROBE, ST_HOLD} state_t;
    typedef enum logic [1:0] {OWN_WR, OWN_ALU, OWN_CMP, OWN_SH} owner_t;

    localparam logic [1:0] STROBE_LAST = 2'(STROBE_LEN - 1);

    state_t      state_r;
    owner_t      owner_r;
    owner_t      rr_ptr_r;
    logic [1:0]  cnt_r;
    logic [3:0]  ack_r;
    logic [7:0]  en_r;
    logic        strob_r;
    logic        cleg_r;
    logic        busy_r;

    logic        rr_valid_s;
    owner_t      rr_owner_s;
    logic        grant_s;
    owner_t      grant_owner_s;
    logic [2:0]  grant_sel_s;

    // en vector order: {w_zmvc, w_legy, w8_x, ust_z, ust_v, ust_mc, ust_y, ust_x}
    function automatic logic [7:0] map_en(input owner_t own, input logic [2:0] sel);
        logic [7:0] en;
        en = 8'b0000_0000;
        case (own)
            OWN_WR: begin
                en[7] = sel[0];
                en[6] = sel[1];
                en[5] = sel[2];
            end
            OWN_ALU: begin
                en[4] = sel[0];
                en[3] = sel[1];
                en[2] = sel[2];
            end
            OWN_SH: begin
                en[1] = sel[0];
                en[0] = sel[1];
            end
            default: en = 8'b0000_0000;
        endcase
        return en;
    endfunction

    // ack vector order: {wr, alu, cmp, sh}
    function automatic logic [3:0] ack_onehot(input owner_t own);
        logic [3:0] a;
        case (own)
            OWN_WR:  a = 4'b1000;
            OWN_ALU: a = 4'b0100;
            OWN_CMP: a = 4'b0010;
            OWN_SH:  a = 4'b0001;
            default: a = 4'b0000;
        endcase
        return a;
    endfunction

    // Round-robin scan of ALU/CMP/SH, starting after the last one granted
    always_comb begin
        rr_valid_s = 1'b1;
        rr_owner_s = OWN_ALU;
        case (rr_ptr_r)
            OWN_ALU: begin
                if (cmp_req)      rr_owner_s = OWN_CMP;
                else if (sh_req)  rr_owner_s = OWN_SH;
                else if (alu_req) rr_owner_s = OWN_ALU;
                else              rr_valid_s = 1'b0;
            end
            OWN_CMP: begin
                if (sh_req)       rr_owner_s = OWN_SH;
                else if (alu_req) rr_owner_s = OWN_ALU;
                else if (cmp_req) rr_owner_s = OWN_CMP;
                else              rr_valid_s = 1'b0;
            end
            default: begin
                if (alu_req)      rr_owner_s = OWN_ALU;
                else if (cmp_req) rr_owner_s = OWN_CMP;
                else if (sh_req)  rr_owner_s = OWN_SH;
                else              rr_valid_s = 1'b0;
            end
        endcase
    end

    // Bus write overrides the rotation; pick owner and its select vector
    always_comb begin
        grant_s       = wr_req | rr_valid_s;
        grant_owner_s = OWN_WR;
        grant_sel_s   = 3'b000;
        if (wr_req) begin
            grant_owner_s = OWN_WR;
            grant_sel_s   = wr_sel;
        end else begin
            grant_owner_s = rr_owner_s;
            case (rr_owner_s)
                OWN_ALU: grant_sel_s = alu_sel;
                OWN_SH:  grant_sel_s = {1'b0, sh_sel};
                default: grant_sel_s = 3'b000;
            endcase
        end
    end

    // Sequencer FSM; every output is computed for the state being entered
    always_ff @(posedge clk_sys or negedge zer_) begin
        if (!zer_) begin
            state_r  <= ST_IDLE;
            owner_r  <= OWN_WR;
            rr_ptr_r <= OWN_SH;
            cnt_r    <= 2'd0;
            ack_r    <= 4'b0000;
            en_r     <= 8'b0000_0000;
            strob_r  <= 1'b0;
            cleg_r   <= 1'b1;
            busy_r   <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    ack_r   <= 4'b0000;
                    strob_r <= 1'b0;
                    cleg_r  <= 1'b1;
                    cnt_r   <= 2'd0;
                    if (grant_s) begin
                        state_r <= ST_SETUP;
                        owner_r <= grant_owner_s;
                        en_r    <= map_en(grant_owner_s, grant_sel_s);
                        busy_r  <= 1'b1;
                        if (!wr_req) begin
                            rr_ptr_r <= rr_owner_s;
                        end
                    end else begin
                        en_r   <= 8'b0000_0000;
                        busy_r <= 1'b0;
                    end
                end
                ST_SETUP: begin
                    state_r <= ST_STROBE;
                    strob_r <= 1'b1;
                    cnt_r   <= STROBE_LAST;
                    cleg_r  <= (owner_r != OWN_CMP);
                end
                ST_STROBE: begin
                    // LEG clock is low only for the first strobe cycle
                    cleg_r <= 1'b1;
                    if (cnt_r == 2'd0) begin
                        state_r <= ST_HOLD;
                        strob_r <= 1'b0;
                        ack_r   <= ack_onehot(owner_r);
                    end else begin
                        cnt_r <= cnt_r - 2'd1;
                    end
                end
                ST_HOLD: begin
                    state_r <= ST_IDLE;
                    ack_r   <= 4'b0000;
                    en_r    <= 8'b0000_0000;
                    busy_r  <= 1'b0;
                end
                default: begin
                    state_r <= ST_IDLE;
                    ack_r   <= 4'b0000;
                    en_r    <= 8'b0000_0000;
                    strob_r <= 1'b0;
                    cleg_r  <= 1'b1;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

    assign {wr_ack, alu_ack, cmp_ack, sh_ack} = ack_r;
    assign {w_zmvc, w_legy, w8_x, ust_z, ust_v, ust_mc, ust_y, ust_x} = en_r;
    assign strob1 = strob_r;
    assign cleg_  = cleg_r;
    assign busy   = busy_r;

endmodule
